// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_input_sequencer
// Brief    : Latches A/B/op from a switch bank on debounced button edges,
//            runs one ALU execute cycle and holds the captured result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_input_sequencer #(
    parameter int NB_OP = 6,
    parameter int NB_AB = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NB_AB-1:0] i_sw,
    input  logic [2:0]       i_btn,
    output logic [NB_AB-1:0] o_alu_a,
    output logic [NB_AB-1:0] o_alu_b,
    output logic [NB_OP-1:0] o_alu_op,
    input  logic [NB_AB-1:0] i_alu_result,
    output logic [NB_AB-1:0] o_result,
    output logic             o_valid,
    output logic [2:0]       o_loaded,
    output logic [1:0]       o_state
);

    localparam logic [1:0] ST_COLLECT = 2'b00;
    localparam logic [1:0] ST_EXEC    = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    logic [2:0]       sync1_q, sync2_q, dly_q;
    logic [2:0]       w_pulse;

    logic [NB_AB-1:0] a_q, a_d;
    logic [NB_AB-1:0] b_q, b_d;
    logic [NB_OP-1:0] op_q, op_d;
    logic [NB_AB-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic [2:0]       loaded_q, loaded_d;
    logic [1:0]       state_q, state_d;

    // Two-flop synchronizer followed by an edge-detect flop per button.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            dly_q   <= 3'b000;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign w_pulse = sync2_q & ~dly_q;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        valid_d  = valid_q;
        loaded_d = loaded_q;
        state_d  = state_q;

        case (state_q)
            ST_COLLECT: begin
                if (w_pulse[0]) a_d  = i_sw;
                if (w_pulse[1]) b_d  = i_sw;
                if (w_pulse[2]) op_d = i_sw[NB_OP-1:0];
                loaded_d = loaded_q | w_pulse;
                if (loaded_d == 3'b111) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = i_alu_result;
                valid_d  = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                // A new press starts a fresh operand set; only the pulsed flags survive.
                if (|w_pulse) begin
                    if (w_pulse[0]) a_d  = i_sw;
                    if (w_pulse[1]) b_d  = i_sw;
                    if (w_pulse[2]) op_d = i_sw[NB_OP-1:0];
                    loaded_d = w_pulse;
                    valid_d  = 1'b0;
                    state_d  = ST_COLLECT;
                end
            end
            default: begin
                loaded_d = 3'b000;
                state_d  = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            loaded_q <= 3'b000;
            state_q  <= ST_COLLECT;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            loaded_q <= loaded_d;
            state_q  <= state_d;
        end
    end

    assign o_alu_a  = a_q;
    assign o_alu_b  = b_q;
    assign o_alu_op = op_q;
    assign o_result = result_q;
    assign o_valid  = valid_q;
    assign o_loaded = loaded_q;
    assign o_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_input_sequencer
// Brief    : Directed self-checking bench for alu_input_sequencer with a
//            small ALU model (100000 = A+B, 000011 = A>>>B).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_input_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_sw  = 8'h00;
    logic [2:0] i_btn = 3'b000;
    logic [7:0] o_alu_a, o_alu_b, o_result, alu_res;
    logic [5:0] o_alu_op;
    logic       o_valid;
    logic [2:0] o_loaded;
    logic [1:0] o_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    always_comb begin
        case (o_alu_op)
            6'b100000: alu_res = o_alu_a + o_alu_b;
            6'b000011: alu_res = 8'($signed(o_alu_a) >>> o_alu_b);
            default:   alu_res = 8'h00;
        endcase
    end

    alu_input_sequencer #(.NB_OP(6), .NB_AB(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_sw         (i_sw),
        .i_btn        (i_btn),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_result (alu_res),
        .o_result     (o_result),
        .o_valid      (o_valid),
        .o_loaded     (o_loaded),
        .o_state      (o_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [2:0] m, input logic [7:0] sw, input int hold);
        i_sw  = sw;
        i_btn = m;
        repeat (hold) tick();
        i_btn = 3'b000;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({o_alu_a, o_alu_b, o_alu_op, o_result} !== 30'd0) begin n_err++; $display("FAIL rst_regs a=%h b=%h op=%h res=%h want 0", o_alu_a, o_alu_b, o_alu_op, o_result); end
        n_cmp++; if ({o_valid, o_loaded, o_state} !== 6'b0) begin n_err++; $display("FAIL rst_flags v=%b ld=%b st=%b want 0", o_valid, o_loaded, o_state); end
        reset = 1'b0;
        tick();
    endtask

    // Test 1: load sequence, state walk, result two edges after the op pulse edge.
    task automatic test_basic();
        press(3'b001, 8'h0F, 4);
        n_cmp++; if (o_loaded !== 3'b001 || o_alu_a !== 8'h0F || o_state !== 2'b00) begin n_err++; $display("FAIL t1_loadA ld=%b a=%h st=%b want 001/0f/00", o_loaded, o_alu_a, o_state); end
        press(3'b010, 8'h01, 4);
        n_cmp++; if (o_loaded !== 3'b011 || o_alu_b !== 8'h01) begin n_err++; $display("FAIL t1_loadB ld=%b b=%h want 011/01", o_loaded, o_alu_b); end
        i_sw = 8'h03; i_btn = 3'b100;
        tick();
        tick();
        n_cmp++; if (o_alu_op !== 6'h00 || o_state !== 2'b00) begin n_err++; $display("FAIL t1_op_early op=%h st=%b want 00/00", o_alu_op, o_state); end
        tick();
        n_cmp++; if (o_alu_op !== 6'h03 || o_loaded !== 3'b111 || o_state !== 2'b01 || o_valid !== 1'b0) begin n_err++; $display("FAIL t1_exec op=%h ld=%b st=%b v=%b want 03/111/01/0", o_alu_op, o_loaded, o_state, o_valid); end
        tick();
        n_cmp++; if (o_state !== 2'b10 || o_valid !== 1'b1 || o_result !== 8'h07) begin n_err++; $display("FAIL t1_done st=%b v=%b res=%h want 10/1/07", o_state, o_valid, o_result); end
        i_btn = 3'b000;
        repeat (4) tick();
        n_cmp++; if (o_valid !== 1'b1 || o_result !== 8'h07 || o_state !== 2'b10) begin n_err++; $display("FAIL t1_hold v=%b res=%h st=%b want 1/07/10", o_valid, o_result, o_state); end
    endtask

    // Test 2: reload from DONE, arithmetic shift of a negative operand.
    task automatic test_reload_shift();
        press(3'b001, 8'h8F, 4);
        n_cmp++; if (o_valid !== 1'b0 || o_loaded !== 3'b001 || o_result !== 8'h07 || o_state !== 2'b00) begin n_err++; $display("FAIL t2_reopen v=%b ld=%b res=%h st=%b want 0/001/07/00", o_valid, o_loaded, o_result, o_state); end
        press(3'b010, 8'h01, 4);
        press(3'b100, 8'h03, 4);
        n_cmp++; if (o_result !== 8'hC7 || o_valid !== 1'b1 || o_state !== 2'b10) begin n_err++; $display("FAIL t2_sra res=%h v=%b st=%b want c7/1/10", o_result, o_valid, o_state); end
    endtask

    // Test 3: long hold and single-cycle glitch each give exactly one load.
    task automatic test_hold_glitch();
        i_sw = 8'h11; i_btn = 3'b001;
        tick();
        tick();
        n_cmp++; if (o_alu_a !== 8'h8F) begin n_err++; $display("FAIL t3_early a=%h want 8f", o_alu_a); end
        tick();
        n_cmp++; if (o_alu_a !== 8'h11 || o_loaded !== 3'b001 || o_valid !== 1'b0) begin n_err++; $display("FAIL t3_first a=%h ld=%b v=%b want 11/001/0", o_alu_a, o_loaded, o_valid); end
        i_sw = 8'h22;
        repeat (47) tick();
        n_cmp++; if (o_alu_a !== 8'h11) begin n_err++; $display("FAIL t3_held a=%h want 11", o_alu_a); end
        i_btn = 3'b000;
        repeat (4) tick();
        i_sw = 8'h33; i_btn = 3'b001;
        tick();
        i_btn = 3'b000;
        tick();
        tick();
        n_cmp++; if (o_alu_a !== 8'h33) begin n_err++; $display("FAIL t3_glitch a=%h want 33", o_alu_a); end
        i_sw = 8'h44;
        repeat (4) tick();
        n_cmp++; if (o_alu_a !== 8'h33) begin n_err++; $display("FAIL t3_glitch_once a=%h want 33", o_alu_a); end
        press(3'b010, 8'h01, 4);
        press(3'b100, 8'h20, 4);
        n_cmp++; if (o_result !== 8'h34 || o_valid !== 1'b1 || o_state !== 2'b10) begin n_err++; $display("FAIL t3_add res=%h v=%b st=%b want 34/1/10", o_result, o_valid, o_state); end
    endtask

    // Test 4: all three buttons together from DONE.
    task automatic test_simultaneous();
        i_sw = 8'h20; i_btn = 3'b111;
        repeat (3) tick();
        n_cmp++; if (o_state !== 2'b00 || o_loaded !== 3'b111 || o_valid !== 1'b0 || o_result !== 8'h34) begin n_err++; $display("FAIL t4_collect st=%b ld=%b v=%b res=%h want 00/111/0/34", o_state, o_loaded, o_valid, o_result); end
        n_cmp++; if (o_alu_a !== 8'h20 || o_alu_b !== 8'h20 || o_alu_op !== 6'h20) begin n_err++; $display("FAIL t4_regs a=%h b=%h op=%h want 20/20/20", o_alu_a, o_alu_b, o_alu_op); end
        tick();
        n_cmp++; if (o_state !== 2'b01) begin n_err++; $display("FAIL t4_exec st=%b want 01", o_state); end
        tick();
        n_cmp++; if (o_state !== 2'b10 || o_result !== 8'h40 || o_valid !== 1'b1) begin n_err++; $display("FAIL t4_done st=%b res=%h v=%b want 10/40/1", o_state, o_result, o_valid); end
        i_btn = 3'b000;
        repeat (4) tick();
    endtask

    // Test 5: overwrite in COLLECT; a B pulse landing in EXEC is ignored.
    task automatic test_overwrite_exec_ignore();
        press(3'b001, 8'h0F, 4);
        press(3'b001, 8'h05, 4);
        n_cmp++; if (o_alu_a !== 8'h05 || o_loaded !== 3'b001 || o_state !== 2'b00) begin n_err++; $display("FAIL t5_overwrite a=%h ld=%b st=%b want 05/001/00", o_alu_a, o_loaded, o_state); end
        press(3'b010, 8'h03, 4);
        n_cmp++; if (o_loaded !== 3'b011) begin n_err++; $display("FAIL t5_loadB ld=%b want 011", o_loaded); end
        i_sw = 8'h20; i_btn = 3'b100;
        tick();
        i_btn = 3'b110;
        tick();
        tick();
        n_cmp++; if (o_state !== 2'b01 || o_alu_op !== 6'h20) begin n_err++; $display("FAIL t5_exec st=%b op=%h want 01/20", o_state, o_alu_op); end
        tick();
        n_cmp++; if (o_state !== 2'b10 || o_result !== 8'h08 || o_alu_b !== 8'h03 || o_loaded !== 3'b111) begin n_err++; $display("FAIL t5_done st=%b res=%h b=%h ld=%b want 10/08/03/111", o_state, o_result, o_alu_b, o_loaded); end
        tick();
        i_btn = 3'b000;
        repeat (4) tick();
        n_cmp++; if (o_alu_b !== 8'h03 || o_loaded !== 3'b111 || o_state !== 2'b10 || o_valid !== 1'b1) begin n_err++; $display("FAIL t5_after b=%h ld=%b st=%b v=%b want 03/111/10/1", o_alu_b, o_loaded, o_state, o_valid); end
    endtask

    // Test 6: reset in EXEC with button 0 held through reset.
    task automatic test_reset_in_exec();
        press(3'b001, 8'h0F, 4);
        press(3'b010, 8'h01, 4);
        i_sw = 8'h03; i_btn = 3'b100;
        repeat (3) tick();
        n_cmp++; if (o_state !== 2'b01) begin n_err++; $display("FAIL t6_in_exec st=%b want 01", o_state); end
        reset = 1'b1; i_btn = 3'b001; i_sw = 8'h5A;
        tick();
        n_cmp++; if ({o_alu_a, o_alu_b, o_alu_op, o_result} !== 30'd0 || {o_valid, o_loaded, o_state} !== 6'b0) begin n_err++; $display("FAIL t6_reset a=%h b=%h op=%h res=%h v=%b ld=%b st=%b want all 0", o_alu_a, o_alu_b, o_alu_op, o_result, o_valid, o_loaded, o_state); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (o_alu_a !== 8'h00 || o_valid !== 1'b0) begin n_err++; $display("FAIL t6_early a=%h v=%b want 00/0", o_alu_a, o_valid); end
        tick();
        n_cmp++; if (o_alu_a !== 8'h5A || o_loaded !== 3'b001) begin n_err++; $display("FAIL t6_held_load a=%h ld=%b want 5a/001", o_alu_a, o_loaded); end
        i_sw = 8'h66;
        repeat (10) tick();
        n_cmp++; if (o_alu_a !== 8'h5A || o_loaded !== 3'b001 || o_state !== 2'b00 || o_valid !== 1'b0) begin n_err++; $display("FAIL t6_once a=%h ld=%b st=%b v=%b want 5a/001/00/0", o_alu_a, o_loaded, o_state, o_valid); end
        i_btn = 3'b000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload_shift();
        test_hold_glitch();
        test_simultaneous();
        test_overwrite_exec_ignore();
        test_reset_in_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
Board-level controller that sequences the shared combinational ALU (NB_OP-bit operation, NB_AB-bit signed operands) from one switch bank and three push buttons. Each button synchronously latches the switch value into the A, B or operation register. Once all three are loaded, the block runs one execute cycle, registers the ALU result and holds it with a valid flag for display. It sits between the board I/O (switches, buttons, LEDs) and the ALU instance.

Parameters:
NB_OP, 6, operation code width.
NB_AB, 8, operand and result width; also the switch bank width (must be >= NB_OP).

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
i_sw  input  NB_AB  raw switch value (asynchronous to clock).
i_btn  input  3  raw buttons (asynchronous): [0] load A, [1] load B, [2] load operation.
o_alu_a  output  NB_AB  A register, drives ALU i_Adata.
o_alu_b  output  NB_AB  B register, drives ALU i_Bdata.
o_alu_op  output  NB_OP  operation register, drives ALU i_operation.
i_alu_result  input  NB_AB  combinational ALU output.
o_result  output  NB_AB  captured result.
o_valid  output  1  o_result belongs to the current A/B/op set.
o_loaded  output  3  per-register loaded flags (bit order as i_btn).
o_state  output  2  FSM state: 00 COLLECT, 01 EXEC, 10 DONE.

Behaviour:
- Reset (sync, active-high; wins over everything): A, B, op, o_result = 0; o_valid = 0; o_loaded = 000; state = COLLECT; synchronizer and edge flops = 0.
- Per button: 2-flop synchronizer, then a delay flop. load_pulse = sync2 & ~delay. Button first sampled high at edge N -> register updates at edge N+2. One pulse per press regardless of hold length. A button held through reset produces one pulse after reset deasserts.
- Loads: A <= i_sw; B <= i_sw; op <= i_sw[NB_OP-1:0]. Simultaneous pulses all load in the same cycle.
- COLLECT:
  - A pulse loads its register and sets its o_loaded bit.
  - A repeat load overwrites the register; its flag stays set.
  - At the edge where o_loaded becomes 111, state -> EXEC.
- EXEC (exactly 1 cycle):
  - o_alu_* are stable.
  - At the end of the cycle, o_result <= i_alu_result, o_valid <= 1, state -> DONE.
  - Load pulses arriving in EXEC are ignored: no register change, no flag change.
  - Latency: last load edge E -> o_valid = 1 and o_result valid after edge E+2.
- DONE:
  - o_result, o_valid and the operand registers hold indefinitely.
  - Any load pulse: the pulsed register(s) load; o_loaded <= the pulsed bits only (others cleared); o_valid <= 0; state -> COLLECT. o_result keeps the old value until the next capture.
  - If all three pulse simultaneously in DONE, state -> COLLECT with o_loaded = 111, then -> EXEC on the next edge.
- o_state encoding 11 is unreachable; if entered, the next state is COLLECT with o_loaded = 000.
- Signed interpretation is the ALU's concern; this block only transports bits, no width changes except op truncation.
- Reset asserted mid-EXEC or mid-DONE: all registers and outputs return to reset values on that edge; no capture occurs.

Test Plan:
(Bench ALU model: op 6'b100000 = A+B, op 6'b000011 = A>>>B.)
1. After reset, press A(sw=0x0F), B(sw=0x01), op(sw=0x03), each held 4 cycles -> o_loaded 001/011/111; o_state 00->01->10; o_result = 0x07, o_valid = 1 exactly 2 edges after the op load.
2. In DONE, press A with sw=0x8F -> o_valid drops, o_loaded = 001, o_result still 0x07. Then press B=0x01 and op=0x03 -> o_result = 0xC7 (arithmetic shift), o_valid = 1.
3. Hold button 0 for 50 cycles -> exactly one load, and A is updated 2 edges after first sample. A glitch high for 1 cycle is still one load.
4. In DONE, press all three buttons on the same cycle with sw=0x20 and op code 6'b100000 -> COLLECT with o_loaded = 111, EXEC, then o_result = 0x40.
5. Press A again while in COLLECT with sw=0x05 after an earlier 0x0F, then complete B=0x03 and op=0x20 -> o_result = 0x08. Also issue a B pulse aligned to EXEC -> B unchanged, o_loaded unaffected.
6. Assert reset during EXEC -> all outputs 0 and o_state = 00 next cycle, no o_valid. A button held through reset loads once after release.
